// File: rtl/event_write_pkg.sv
// event_write_pkg: shared widths, FSM states and ring-buffer wrap-add for the event RAM.
package event_write_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  function automatic logic [DEF_ADDR_W-1:0] wrap_add(
    input logic [DEF_ADDR_W-1:0] base,
    input logic [DEF_LEN_W-1:0]  len,
    input logic [DEF_ADDR_W-1:0] depth
  );
    logic [DEF_ADDR_W:0] s;
    s = {1'b0, base} + (DEF_ADDR_W+1)'(len);
    return (s >= {1'b0, depth}) ? DEF_ADDR_W'(s - {1'b0, depth}) : DEF_ADDR_W'(s);
  endfunction
endpackage

// File: rtl/slot_occupancy.sv
// slot_occupancy: unread-word occupancy of the ring, tracking reservations, aborts and read-side releases.
module slot_occupancy
  import event_write_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              reserve,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] depth,
  input  logic [CNT_W-1:0]  n_read,
  output logic              full
);
  logic [ADDR_W:0]   occ_q, occ_d;
  logic [CNT_W-1:0]  n_read_q;
  logic [ADDR_W+1:0] len_x, sum, dec;
  always_comb begin
    len_x = (ADDR_W+2)'(len);
    sum   = (ADDR_W+2)'(occ_q) + (reserve ? len_x : '0);
    dec   = ((n_read != n_read_q) ? len_x : '0) + (abort ? len_x : '0);
    // a release beyond what is held is a read-side protocol error; clamp rather than wrap
    occ_d = (sum > dec) ? (ADDR_W+1)'(sum - dec) : '0;
    full  = (ADDR_W+2)'(occ_q) + len_x > (ADDR_W+2)'(depth);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= '0;
      n_read_q <= '0;
    end else begin
      occ_q    <= clr ? '0 : occ_d;
      n_read_q <= n_read;
    end
  end
endmodule

// File: rtl/event_write_scheduler.sv
// event_write_scheduler: claims a ring slot on trigger and streams valid samples into it for the read side.
module event_write_scheduler
  import event_write_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH,
  input  logic [ADDR_W-1:0] MEMORY_DEPTH,
  input  logic [CNT_W-1:0]  n_read,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              w_complete,
  output logic              busy,
  output logic              full,
  output logic [CNT_W-1:0]  n_evt,
  output logic [CNT_W-1:0]  drop_cnt
);
  state_t            state_q, state_d;
  logic              live_q, rise, accept, abort;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d, addr_q, addr_d, waddr_q, waddr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d, w_complete_q, w_complete_d;
  logic [CNT_W-1:0]  n_evt_q, n_evt_d, drop_cnt_q, drop_cnt_d;
  assign rise   = live & ~live_q;
  assign accept = (state_q == IDLE) && trig && live && (HALF_PACKAGE_LENGTH != '0) && !full;
  always_comb begin
    state_d      = state_q;
    wr_base_d    = wr_base_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    w_complete_d = 1'b0;
    n_evt_d      = n_evt_q;
    abort        = 1'b0;
    drop_cnt_d   = (trig && !accept && !(&drop_cnt_q)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = wr_base_q;
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: if (!live) begin
        abort   = 1'b1;
        state_d = IDLE;
      end else if (din_valid) begin
        wen_d   = 1'b1;
        waddr_d = addr_q;
        wdata_d = din;
        addr_d  = (addr_q == MEMORY_DEPTH - ADDR_W'(1)) ? '0 : addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = (cnt_q == HALF_PACKAGE_LENGTH - LEN_W'(1)) ? DONE : WRITE;
      end
      DONE: begin
        w_complete_d = 1'b1;
        n_evt_d      = n_evt_q + CNT_W'(1);
        wr_base_d    = wrap_add(wr_base_q, HALF_PACKAGE_LENGTH, MEMORY_DEPTH);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    live_q <= rst_n & live;
    // a fresh run starts from a clean slate, mirroring the read-side clear
    if (!rst_n || rise) begin
      state_q      <= IDLE;
      wr_base_q    <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      w_complete_q <= 1'b0;
      n_evt_q      <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_base_q    <= wr_base_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      w_complete_q <= w_complete_d;
      n_evt_q      <= n_evt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
  slot_occupancy #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_occ (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rise),
    .reserve(accept),
    .abort  (abort),
    .len    (HALF_PACKAGE_LENGTH),
    .depth  (MEMORY_DEPTH),
    .n_read (n_read),
    .full   (full)
  );
  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign w_complete = w_complete_q;
  assign busy       = state_q != IDLE;
  assign n_evt      = n_evt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_event_write_scheduler.sv
// tb_event_write_scheduler: directed checks of slot claim, ring wrap, full/drop, abort and reset behaviour.
module tb_event_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, live, trig, din_valid, wen, w_complete, busy, full;
  logic [15:0] din, n_read, wdata, n_evt, drop_cnt, ld;
  logic [14:0] depth, waddr, lw;
  logic [9:0]  hpl;
  logic [19:0] vpat = 20'hFFFF5;
  logic [19:0] tpat = 20'h00009;
  int          total = 0;
  int          bad = 0;
  int          nw, nc;
  always #5 clk = ~clk;
  event_write_scheduler dut (
    .clk(clk), .rst_n(rst_n), .live(live), .trig(trig), .din(din), .din_valid(din_valid),
    .HALF_PACKAGE_LENGTH(hpl), .MEMORY_DEPTH(depth), .n_read(n_read),
    .wen(wen), .waddr(waddr), .wdata(wdata), .w_complete(w_complete), .busy(busy),
    .full(full), .n_evt(n_evt), .drop_cnt(drop_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic restart(input logic [14:0] d);
    live = 1'b0;
    tick();
    depth = d;
    live = 1'b1;
    tick();
  endtask
  task automatic do_event(input int a0, input int d0, input int evt, input bit bump);
    int a;
    a = a0;
    trig = 1'b1;
    if (bump) n_read = n_read + 16'd1;
    tick();
    trig = 1'b0;
    chk("busy_after_trig", 32'(busy), 1);
    for (int i = 0; i < int'(hpl); i++) begin
      din_valid = 1'b1;
      din = 16'(d0 + i);
      tick();
      chk("wen", 32'(wen), 1);
      chk("waddr", 32'(waddr), a);
      chk("wdata", 32'(wdata), d0 + i);
      chk("w_complete_early", 32'(w_complete), 0);
      a = (a == int'(depth) - 1) ? 0 : a + 1;
    end
    din_valid = 1'b0;
    tick();
    chk("w_complete", 32'(w_complete), 1);
    chk("wen_after_slot", 32'(wen), 0);
    chk("n_evt", 32'(n_evt), evt);
    chk("busy_idle", 32'(busy), 0);
    tick();
    chk("w_complete_pulse", 32'(w_complete), 0);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; live = 1'b0; trig = 1'b0; din_valid = 1'b0; din = '0;
    n_read = '0; hpl = 10'd8; depth = 15'd64;
    tick();
    tick();
    chk("rst_wen", 32'(wen), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_n_evt", 32'(n_evt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    live = 1'b1;
    tick();
    // basic event, then a second one proves wr_base moved to 8
    do_event(0, 'h10, 1, 0);
    do_event(8, 'h20, 2, 0);
    chk("basic_drop", 32'(drop_cnt), 0);
    // wrap-around in a 20-word ring
    restart(15'd20);
    chk("wrap_n_evt_clr", 32'(n_evt), 0);
    do_event(0, 'h100, 1, 0);
    n_read = n_read + 16'd1; tick();
    do_event(8, 'h200, 2, 0);
    n_read = n_read + 16'd1; tick();
    do_event(16, 'h300, 3, 0);
    n_read = n_read + 16'd1; tick();
    do_event(4, 'h400, 4, 0);
    // full and drop with n_read held
    restart(15'd16);
    do_event(0, 'h500, 1, 0);
    do_event(8, 'h600, 2, 0);
    chk("full_set", 32'(full), 1);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("full_drop_cnt", 32'(drop_cnt), 1);
    chk("full_no_busy", 32'(busy), 0);
    tick();
    chk("full_no_wen", 32'(wen), 0);
    n_read = n_read + 16'd1; tick();
    chk("full_released", 32'(full), 0);
    do_event(0, 'h700, 3, 0);
    chk("full_drop_hold", 32'(drop_cnt), 1);
    // triggers while writing, with gaps in din_valid
    restart(15'd64);
    trig = 1'b1; tick();
    nw = 0; nc = 0; lw = '0; ld = '0;
    for (int c = 0; c < 20; c++) begin
      trig = tpat[c];
      din_valid = vpat[c];
      din = 16'(c + 'h40);
      tick();
      if (wen) begin nw++; lw = waddr; ld = wdata; end
      if (w_complete) nc++;
    end
    trig = 1'b0; din_valid = 1'b0;
    chk("busy_writes", nw, 8);
    chk("busy_completes", nc, 1);
    chk("busy_last_waddr", 32'(lw), 7);
    chk("busy_last_wdata", 32'(ld), 'h49);
    chk("busy_drop_cnt", 32'(drop_cnt), 2);
    chk("busy_n_evt", 32'(n_evt), 1);
    // abort after 3 writes in a 12-word ring
    restart(15'd12);
    do_event(0, 'h50, 1, 0);
    n_read = n_read + 16'd1; tick();
    trig = 1'b1; tick(); trig = 1'b0;
    chk("abort_full_held", 32'(full), 1);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; din = 16'('h60 + i); tick();
      chk("abort_wen", 32'(wen), 1);
      chk("abort_waddr", 32'(waddr), 8 + i);
    end
    din_valid = 1'b0; live = 1'b0; tick();
    chk("abort_wen_off", 32'(wen), 0);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_released", 32'(full), 0);
    chk("abort_no_complete", 32'(w_complete), 0);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("abort_dead_drop", 32'(drop_cnt), 1);
    chk("abort_n_evt", 32'(n_evt), 1);
    chk("abort_no_complete2", 32'(w_complete), 0);
    live = 1'b1; tick();
    chk("relive_n_evt", 32'(n_evt), 0);
    chk("relive_drop", 32'(drop_cnt), 0);
    do_event(0, 'h70, 1, 0);
    // reset in the middle of a slot
    n_read = n_read + 16'd1; tick();
    trig = 1'b1; tick(); trig = 1'b0;
    din_valid = 1'b1; din = 16'h99; tick(); tick();
    din_valid = 1'b0; rst_n = 1'b0; depth = 15'd16; tick();
    chk("mid_rst_wen", 32'(wen), 0);
    chk("mid_rst_waddr", 32'(waddr), 0);
    chk("mid_rst_wdata", 32'(wdata), 0);
    chk("mid_rst_wcmp", 32'(w_complete), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_n_evt", 32'(n_evt), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1; tick();
    do_event(0, 'h80, 1, 0);
    chk("pre_same_full", 32'(full), 0);
    // accept and release together leave occupancy at one slot
    do_event(8, 'h90, 2, 1);
    chk("same_cycle_full", 32'(full), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
